dct_scheduler: RTL
==================

DCT_SCHEDULER -- requirements
Module: dct_scheduler

Interface
REQ-001 Parameter SHALL be: WAIT_CYCLES, 1, number of memory read latency cycles between Read_Enable and Active_MAC (legal range 1..4).
REQ-002 Clock  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  level; sampled only in IDLE; begins a full 8x8 transform.
REQ-005 Out_Ready  input  1  output-memory acceptance for the current write.
REQ-006 Busy  output  1  high in every state except IDLE.
REQ-007 Ready  output  1  one-cycle pulse in DONE.
REQ-008 u, v, x, y  output  3 each  current coefficient index (u,v) and output point (x,y), for the cosine ROM.
REQ-009 Read_Enable  output  1  high in ISSUE only.
REQ-010 Address  output  6  {u,v}, input-memory read address.
REQ-011 Clear_MAC  output  1  high in CLEAR only.
REQ-012 Active_MAC  output  1  high in ACCUM only.
REQ-013 Write_Enable  output  1  high in WRITE only.
REQ-014 Write_Address  output  6  {x,y}, output-memory write address.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, ISSUE, WAIT, ACCUM, WRITE, DONE; all outputs are Moore (state/counter decodes only).
REQ-016 IDLE -> CLEAR when Start=1; otherwise stay; u, v, x, y SHALL be held at 0 in IDLE.
REQ-017 CLEAR -> ISSUE after exactly one cycle.
REQ-018 ISSUE -> WAIT after one cycle; WAIT SHALL last exactly WAIT_CYCLES cycles via a down-counter, then -> ACCUM.
REQ-019 ACCUM lasts one cycle; on exit v increments; v=7 wraps to 0 and u increments; if (u,v)=(7,7) then next state is WRITE with (u,v) reset to (0,0), else ISSUE.
REQ-020 WRITE SHALL hold Write_Enable and Write_Address stable until Out_Ready=1; on that cycle y increments, y=7 wraps to 0 and x increments.
REQ-021 WRITE with Out_Ready=1: if (x,y)=(7,7) -> DONE with (x,y) reset to (0,0), else -> CLEAR.
REQ-022 DONE lasts one cycle (Ready=1) then -> IDLE; Start high in DONE SHALL be ignored.
REQ-023 Start asserted outside IDLE SHALL have no effect; Start held high continuously SHALL begin a new transform on the cycle after returning to IDLE.
REQ-024 Per point, with Out_Ready=1: 1 (CLEAR) + 64*(2+WAIT_CYCLES) + 1 (WRITE) cycles; WAIT_CYCLES=1 gives 194 cycles per point, 12416 for all 64 points, Ready at cycle 12418 after the Start-sampling edge (IDLE cycle counted as 1).
REQ-025 Each point SHALL receive exactly 64 Active_MAC pulses between its Clear_MAC and its Write_Enable, in (u,v) order (0,0),(0,1)...(7,7).
REQ-026 Address in ACCUM SHALL equal the value driven in the preceding ISSUE.

Reset
REQ-027 Reset=1 at a rising edge SHALL force IDLE and u=v=x=y=0 regardless of state, including mid-WAIT or mid-WRITE stall.
REQ-028 Cycle after reset: Busy, Ready, Read_Enable, Clear_MAC, Active_MAC, Write_Enable = 0; Address = Write_Address = 0.
REQ-029 Reset SHALL take priority over Start in the same cycle.

Structure
REQ-030 Shared package dct_pkg SHALL hold the state encoding, the 8-point dimension constant and the 3-bit index width.
REQ-031 One sub-module idx_counter_2d (3-bit row/column counter with increment, clear and last-index flag) SHALL be instantiated twice: (u,v) and (x,y).

Verification
REQ-032 Reset, Start=1 one cycle, Out_Ready=1 -> Ready pulse exactly 12418 cycles later; 64 Write_Enable pulses, Write_Address 0..63 in order.
REQ-033 Count Active_MAC between consecutive Clear_MAC pulses -> exactly 64 each; Address sequence 0..63 each point.
REQ-034 Out_Ready=0 for 10 cycles at point (3,5) -> Write_Enable held 11 cycles, Write_Address=0x1D stable, no Read_Enable during stall.
REQ-035 Reset asserted during WAIT of point (2,1) term (4,6) -> next cycle IDLE, all strobes 0, u=v=x=y=0; new Start runs full 12418 cycles.
REQ-036 Start pulsed again while Busy and in DONE -> ignored; only one Ready pulse.
REQ-037 WAIT_CYCLES=3 -> Read_Enable-to-Active_MAC distance 4 cycles; 322 cycles per point.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared definitions for the 8x8 DCT scheduler.
//   DCT_N      : transform dimension (points per row/column)
//   IDX_W      : width of one row/column index
//   WAIT_CNT_W : width of the memory-latency down-counter (WAIT_CYCLES <= 4)
//   state_t    : scheduler FSM encoding
//   pack_idx   : {row, col} -> 6-bit memory address
package dct_pkg;

   localparam int DCT_N      = 8;
   localparam int IDX_W      = 3;
   localparam int ADDR_W     = 2 * IDX_W;
   localparam int WAIT_CNT_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_ACCUM = 3'd4,
      ST_WRITE = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   function automatic logic [ADDR_W-1:0] pack_idx(input logic [IDX_W-1:0] row,
                                                  input logic [IDX_W-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/idx_counter_2d.sv
// Row/column index counter over an DCT_N x DCT_N grid, column fastest.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   i_clr  : synchronous clear to (0,0)
//   i_inc  : advance one position; (7,7) wraps back to (0,0)
//   o_row  : current row index
//   o_col  : current column index
//   o_last : high while the counter sits on (7,7)
module idx_counter_2d
   import dct_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [IDX_W-1:0] o_row,
   output logic [IDX_W-1:0] o_col,
   output logic             o_last
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DCT_N - 1);

   logic [IDX_W-1:0] r_row;
   logic [IDX_W-1:0] r_col;

   // Row overflow at (7,7) wraps naturally to 0, so the last increment of a
   // sweep leaves the counter back at (0,0) without a separate clear.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_inc) begin
         if (r_col == LAST_IDX) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_row  = r_row;
   assign o_col  = r_col;
   assign o_last = (r_row == LAST_IDX) && (r_col == LAST_IDX);

endmodule

// File: rtl/dct_scheduler.sv
// Control sequencer for a full 8x8 DCT: for every output point (x,y) it
// clears the MAC, walks all 64 coefficients (u,v) through the input-memory
// read latency, then writes the point with Out_Ready back-pressure.
//   i_clk / i_rst           : clock, synchronous active-high reset
//   i_start                 : level, sampled only in IDLE
//   i_out_ready             : output memory accepts the current write
//   o_busy / o_ready        : not-IDLE flag / one-cycle completion pulse
//   o_u, o_v, o_x, o_y      : cosine ROM indices
//   o_read_enable, o_address: input-memory read strobe and {u,v}
//   o_clear_mac, o_active_mac: MAC control strobes
//   o_write_enable, o_write_address: output-memory write strobe and {x,y}
//
// state | meaning
// IDLE  | waiting for Start, all indices held at 0
// CLEAR | zero the MAC for the current point (x,y)
// ISSUE | read input sample {u,v}
// WAIT  | memory read latency, WAIT_CYCLES cycles
// ACCUM | MAC the returned sample, advance (u,v)
// WRITE | hold the result until Out_Ready, advance (x,y)
// DONE  | one-cycle Ready pulse
module dct_scheduler
   import dct_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_out_ready,
   output logic              o_busy,
   output logic              o_ready,
   output logic [IDX_W-1:0]  o_u,
   output logic [IDX_W-1:0]  o_v,
   output logic [IDX_W-1:0]  o_x,
   output logic [IDX_W-1:0]  o_y,
   output logic              o_read_enable,
   output logic [ADDR_W-1:0] o_address,
   output logic              o_clear_mac,
   output logic              o_active_mac,
   output logic              o_write_enable,
   output logic [ADDR_W-1:0] o_write_address
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

   state_t                r_state;
   state_t                w_next_state;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   logic                  w_uv_inc;
   logic                  w_xy_inc;
   logic                  w_uv_last;
   logic                  w_xy_last;
   logic                  w_idle;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Loaded in ISSUE so WAIT exits on terminal count after WAIT_CYCLES cycles.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wait_cnt <= '0;
      end else if (r_state == ST_ISSUE) begin
         r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
         r_wait_cnt <= r_wait_cnt - 1'b1;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_uv_inc     = 1'b0;
      w_xy_inc     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_next_state = ST_CLEAR;
            end
         end
         ST_CLEAR: w_next_state = ST_ISSUE;
         ST_ISSUE: w_next_state = ST_WAIT;
         ST_WAIT: begin
            if (r_wait_cnt == '0) begin
               w_next_state = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            w_uv_inc     = 1'b1;
            w_next_state = w_uv_last ? ST_WRITE : ST_ISSUE;
         end
         ST_WRITE: begin
            if (i_out_ready) begin
               w_xy_inc     = 1'b1;
               w_next_state = w_xy_last ? ST_DONE : ST_CLEAR;
            end
         end
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   assign w_idle = (r_state == ST_IDLE);

   idx_counter_2d u_uv_cnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (w_idle),
      .i_inc  (w_uv_inc),
      .o_row  (o_u),
      .o_col  (o_v),
      .o_last (w_uv_last)
   );

   idx_counter_2d u_xy_cnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (w_idle),
      .i_inc  (w_xy_inc),
      .o_row  (o_x),
      .o_col  (o_y),
      .o_last (w_xy_last)
   );

   assign o_busy          = !w_idle;
   assign o_ready         = (r_state == ST_DONE);
   assign o_read_enable   = (r_state == ST_ISSUE);
   assign o_clear_mac     = (r_state == ST_CLEAR);
   assign o_active_mac    = (r_state == ST_ACCUM);
   assign o_write_enable  = (r_state == ST_WRITE);
   assign o_address       = pack_idx(o_u, o_v);
   assign o_write_address = pack_idx(o_x, o_y);

endmodule
